// File: rtl/gf_mult_serial.sv
// gf_mult_serial: digit-serial GF(2^W) multiplier with a runtime reduction
// polynomial and a start/busy/done handshake. Consumes DIGIT bits of A per
// clock, MSB first, so a multiply takes N = W/DIGIT RUN cycles.
// Optional feature macro: GF_MAC_EN. When it is defined, an acc_en input is
// added, and the finished product is XORed into the previous result
// (multiply-accumulate).
module gf_mult_serial #(
   parameter int W     = 8,
   parameter int DIGIT = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W:0]   poly,
`ifdef GF_MAC_EN
   input  logic         acc_en,
`endif
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result
);

   localparam int N  = W / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   // Reject unusable geometries at elaboration.
   generate
      if (DIGIT < 1 || W < 2 || (W % DIGIT) != 0) begin : g_bad_param
         $error("gf_mult_serial: W must be >= 2 and a multiple of DIGIT");
      end
   endgenerate

   typedef enum logic {IDLE, RUN} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  count_q, count_d;
   logic [W-1:0]   acc_q,   acc_d;
   logic [W-1:0]   a_q,     a_d;
   logic [W-1:0]   b_q,     b_d;
   logic [W:0]     poly_q,  poly_d;
   logic [W-1:0]   result_q, result_d;
   logic           done_q,  done_d;
`ifdef GF_MAC_EN
   logic           acc_en_q, acc_en_d;
`endif

   // The accumulator is W+1 bits wide during a sub-step. Its top bit is
   // always discarded by the next shift, so only W bits are held between
   // cycles.
   logic [W:0]     step;
   logic [W-1:0]   acc_next;

   // One RUN cycle of Horner evaluation: DIGIT shift/reduce/add sub-steps.
   // a_q is shifted left each cycle, so the current digit is always at its MSBs.
   always_comb begin
      step = {1'b0, acc_q};
      for (int j = 0; j < DIGIT; j++) begin
         step = {step[W-1:0], 1'b0};
         if (step[W])
            step = step ^ poly_q;
         if (a_q[W-1-j])
            step = step ^ {1'b0, b_q};
      end
      acc_next = step[W-1:0];
   end

   // Next-state and datapath control for the IDLE/RUN sequencer.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      acc_d    = acc_q;
      a_d      = a_q;
      b_d      = b_q;
      poly_d   = poly_q;
      result_d = result_q;
      done_d   = 1'b0;
`ifdef GF_MAC_EN
      acc_en_d = acc_en_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               poly_d  = poly;
               acc_d   = '0;
               count_d = '0;
               state_d = RUN;
`ifdef GF_MAC_EN
               acc_en_d = acc_en;
`endif
            end
         end
         RUN: begin
            acc_d   = acc_next;
            a_d     = a_q << DIGIT;
            count_d = count_q + 1'b1;
            if (count_q == CW'(N - 1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
`ifdef GF_MAC_EN
               result_d = acc_en_q ? (acc_next ^ result_q) : acc_next;
`else
               result_d = acc_next;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and operand registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         count_q  <= '0;
         acc_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         poly_q   <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
`ifdef GF_MAC_EN
         acc_en_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         acc_q    <= acc_d;
         a_q      <= a_d;
         b_q      <= b_d;
         poly_q   <= poly_d;
         result_q <= result_d;
         done_q   <= done_d;
`ifdef GF_MAC_EN
         acc_en_q <= acc_en_d;
`endif
      end
   end

   assign busy   = (state_q == RUN);
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_gf_mult_serial.sv
// tb_gf_mult_serial: directed and random checks of gf_mult_serial against an
// independent carry-less multiply plus long-division reduction model.
module tb_gf_mult_serial;

   localparam int W     = 8;
   localparam int DIGIT = 1;
   localparam int N     = W / DIGIT;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [W:0]   poly = '0;
`ifdef GF_MAC_EN
   logic         acc_en = 1'b0;
`endif
   logic         busy;
   logic         done;
   logic [W-1:0] result;

   gf_mult_serial #(.W(W), .DIGIT(DIGIT)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .poly   (poly),
`ifdef GF_MAC_EN
      .acc_en (acc_en),
`endif
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] model_res = '0;
   logic         prev_done = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Schoolbook carry-less product, then reduce from the top bit down.
   function automatic logic [W-1:0] gf_ref(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [W:0] p);
      logic [2*W-1:0] prod;
      prod = '0;
      for (int i = 0; i < W; i++)
         if (y[i]) prod = prod ^ ({{W{1'b0}}, x} << i);
      for (int i = 2*W-2; i >= W; i--)
         if (prod[i]) prod = prod ^ ({{(W-1){1'b0}}, p} << (i - W));
      return prod[W-1:0];
   endfunction

   // Scoreboard consumer: every done pops one expected result.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0)
            chk("spurious_done", done, 1'b0);
         else
            chk("result", result, exp_q.pop_front());
         chk("done_width", prev_done, 1'b0);
      end
      prev_done <= done;
   end

   // Launch one op at a negedge with the DUT idle; returns at the done negedge.
   // noise: 0 = start low while busy, 1 = random start pulses, 2 = start held high.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [W:0] tp,
                        input logic ten, input int noise);
      int cyc;
      int bh;
      logic [W-1:0] prod;
      a = ta; b = tb; poly = tp; start = 1'b1;
`ifdef GF_MAC_EN
      acc_en = ten;
      prod = gf_ref(ta, tb, tp);
      model_res = ten ? (prod ^ model_res) : prod;
`else
      prod = gf_ref(ta, tb, tp);
      model_res = prod;
      if (ten) model_res = prod;
`endif
      exp_q.push_back(model_res);
      cyc = 0;
      bh  = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (busy) bh++;
         // Scramble the inputs: they must have no effect during RUN.
         a = W'($urandom); b = W'($urandom); poly = (W+1)'($urandom);
`ifdef GF_MAC_EN
         acc_en = 1'($urandom);
`endif
         case (noise)
            1: start = 1'($urandom);
            2: start = 1'b1;
            default: start = 1'b0;
         endcase
      end while (!done && cyc < 4*N + 10);
      start = 1'b0;
      chk("done_seen", done, 1'b1);
      chk("start_to_done", cyc, N + 1);
      chk("busy_cycles", bh, N);
      chk("busy_low_at_done", busy, 1'b0);
   endtask

   initial begin
      // Reset state.
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_result", result, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors.
      do_op(8'h02, 8'h80, 9'h169, 1'b0, 0); chk("mds_02x80", result, 8'h69);
      do_op(8'h02, 8'h80, 9'h14D, 1'b0, 0); chk("rs_02x80",  result, 8'h4D);
      do_op(8'h03, 8'h80, 9'h169, 1'b0, 0); chk("mds_03x80", result, 8'hE9);
      do_op(8'hFF, 8'h01, 9'h169, 1'b0, 0); chk("ff_x_01",   result, 8'hFF);
      do_op(8'h00, 8'hA5, 9'h169, 1'b0, 0); chk("zero_a",    result, 8'h00);

      // Result holds between ops.
      repeat (3) @(negedge clk);
      chk("result_hold", result, 8'h00);

      // start held high, and random pulses while busy, back to back.
      for (int i = 0; i < 6; i++)
         do_op(W'($urandom), W'($urandom), {1'b1, W'($urandom)}, 1'b0, (i < 3) ? 2 : 1);

      // Reset in the middle of RUN.
      a = 8'h57; b = 8'h83; poly = 9'h169; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("busy_before_abort", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_result", result, 0);
      chk("abort_done", done, 1'b0);
      exp_q.delete();
      model_res = '0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < N + 2; i++) begin
         @(negedge clk);
         chk("no_done_after_abort", done, 1'b0);
      end
      do_op(8'h02, 8'h80, 9'h169, 1'b0, 0); chk("post_abort", result, 8'h69);

`ifdef GF_MAC_EN
      do_op(8'h02, 8'h80, 9'h169, 1'b0, 0); chk("mac_op1", result, 8'h69);
      do_op(8'h03, 8'h80, 9'h169, 1'b1, 0); chk("mac_op2", result, 8'h80);
      for (int i = 0; i < 20; i++)
         do_op(W'($urandom), W'($urandom), {1'b1, W'($urandom)}, 1'($urandom), 0);
`endif

      // Random ops against the reference model.
      for (int i = 0; i < 200; i++)
         do_op(W'($urandom), W'($urandom), {1'b1, W'($urandom)}, 1'b0, i % 3);

      @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
